csr_counter_ctrl: RTL and testbench

Controller for the machine performance counters mcycle and minstret, each 64 bits wide. Each counter is built from two 32-bit `counter_32` halves. The block computes per-half enable and load for every cycle from retire events, CSR writes and `mcountinhibit`. It also serves CSR reads with a one-cycle registered response. It sits beside the CSR file in the execute/writeback stage.

---
 rtl/csr_counter_pkg.sv | 24 ++
 rtl/counter_32.sv | 27 ++
 rtl/csr_counter_ctrl.sv | 120 ++++++++++++
 tb/tb_csr_counter_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/csr_counter_pkg.sv
// Shared CSR addresses and mcountinhibit bit positions for the mcycle/minstret
// counter controller.
package csr_counter_pkg;

  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

  localparam int INH_CY = 0;
  localparam int INH_IR = 2;

  // Read-only user-mode shadows of the machine counters.
  function automatic logic is_shadow(input logic [11:0] addr);
    return (addr == ADDR_CYCLE)   || (addr == ADDR_CYCLEH) ||
           (addr == ADDR_INSTRET) || (addr == ADDR_INSTRETH);
  endfunction

endpackage

// File: rtl/counter_32.sv
// One counter half: loads data_in or increments by one whenever en is high.
module counter_32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= ld ? data_in : r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/csr_counter_ctrl.sv
// mcycle/minstret controller: per-half enable/load generation, mcountinhibit
// and a one-cycle registered CSR read/response path.
module csr_counter_ctrl
  import csr_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_retire,
  input  logic        csr_we,
  input  logic        csr_re,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_rvalid,
  output logic        csr_hit,
  output logic        csr_illegal
);

  logic             r_inh_cy;
  logic             r_inh_ir;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic             r_hit;
  logic             r_illegal;

  logic [CNT_W-1:0] w_cy_lo, w_cy_hi, w_ir_lo, w_ir_hi;
  logic             w_wr_cy_lo, w_wr_cy_hi, w_wr_ir_lo, w_wr_ir_hi, w_wr_inh;
  logic             w_cy_inc, w_ir_inc;
  logic             w_cy_carry, w_ir_carry;
  logic             w_cy_lo_en, w_cy_hi_en, w_ir_lo_en, w_ir_hi_en;
  logic [31:0]      w_rd_data;
  logic             w_owned;
  logic             w_shadow;
  logic             w_rst;

  assign w_rst = ~rst_n;

  assign w_wr_cy_lo = csr_we && (csr_addr == ADDR_MCYCLE);
  assign w_wr_cy_hi = csr_we && (csr_addr == ADDR_MCYCLEH);
  assign w_wr_ir_lo = csr_we && (csr_addr == ADDR_MINSTRET);
  assign w_wr_ir_hi = csr_we && (csr_addr == ADDR_MINSTRETH);
  assign w_wr_inh   = csr_we && (csr_addr == ADDR_MCOUNTINHIBIT);

  assign w_cy_inc = ~r_inh_cy;
  assign w_ir_inc = instr_retire && ~r_inh_ir;

  // A low-half write replaces the increment, so it must also kill the carry.
  assign w_cy_carry = w_cy_inc && (w_cy_lo == '1) && !w_wr_cy_lo;
  assign w_ir_carry = w_ir_inc && (w_ir_lo == '1) && !w_wr_ir_lo;

  assign w_cy_lo_en = w_cy_inc   || w_wr_cy_lo;
  assign w_cy_hi_en = w_cy_carry || w_wr_cy_hi;
  assign w_ir_lo_en = w_ir_inc   || w_wr_ir_lo;
  assign w_ir_hi_en = w_ir_carry || w_wr_ir_hi;

  counter_32 #(.W(CNT_W)) u_cy_lo (
    .clk(clk), .rst(w_rst), .en(w_cy_lo_en), .ld(w_wr_cy_lo),
    .data_in(csr_wdata), .count(w_cy_lo)
  );
  counter_32 #(.W(CNT_W)) u_cy_hi (
    .clk(clk), .rst(w_rst), .en(w_cy_hi_en), .ld(w_wr_cy_hi),
    .data_in(csr_wdata), .count(w_cy_hi)
  );
  counter_32 #(.W(CNT_W)) u_ir_lo (
    .clk(clk), .rst(w_rst), .en(w_ir_lo_en), .ld(w_wr_ir_lo),
    .data_in(csr_wdata), .count(w_ir_lo)
  );
  counter_32 #(.W(CNT_W)) u_ir_hi (
    .clk(clk), .rst(w_rst), .en(w_ir_hi_en), .ld(w_wr_ir_hi),
    .data_in(csr_wdata), .count(w_ir_hi)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned and infers a latch.
  always_comb begin
    w_rd_data = '0;
    w_owned   = 1'b1;
    unique case (csr_addr)
      ADDR_MCYCLE,    ADDR_CYCLE:    w_rd_data = w_cy_lo;
      ADDR_MCYCLEH,   ADDR_CYCLEH:   w_rd_data = w_cy_hi;
      ADDR_MINSTRET,  ADDR_INSTRET:  w_rd_data = w_ir_lo;
      ADDR_MINSTRETH, ADDR_INSTRETH: w_rd_data = w_ir_hi;
      ADDR_MCOUNTINHIBIT: begin
        w_rd_data[INH_CY] = r_inh_cy;
        w_rd_data[INH_IR] = r_inh_ir;
      end
      default: w_owned = 1'b0;
    endcase
  end

  assign w_shadow = is_shadow(csr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inh_cy  <= 1'b0;
      r_inh_ir  <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_hit     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_wr_inh) begin
        r_inh_cy <= csr_wdata[INH_CY];
        r_inh_ir <= csr_wdata[INH_IR];
      end
      if (csr_re) r_rdata <= w_rd_data;
      r_rvalid  <= csr_re;
      r_hit     <= (csr_re || csr_we) && w_owned;
      r_illegal <= csr_we && w_shadow;
    end
  end

  assign csr_rdata   = r_rdata;
  assign csr_rvalid  = r_rvalid;
  assign csr_hit     = r_hit;
  assign csr_illegal = r_illegal;

endmodule

// File: tb/tb_csr_counter_ctrl.sv
// Directed and random CSR traffic against a 64-bit behavioural model of
// mcycle/minstret/mcountinhibit.
module tb_csr_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_retire = 1'b0;
  logic        csr_we = 1'b0;
  logic        csr_re = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        csr_hit;
  logic        csr_illegal;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: whole 64-bit counters, inhibit word, last read data.
  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_inh, m_rdata;

  csr_counter_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_retire(instr_retire),
    .csr_we(csr_we), .csr_re(csr_re), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .csr_hit(csr_hit), .csr_illegal(csr_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, output logic owned);
    owned = 1'b1;
    case (a)
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'h320:          return m_inh;
      default: begin owned = 1'b0; return 32'h0; end
    endcase
  endfunction

  function automatic logic [63:0] m_next(input logic [63:0] cnt, input logic inc,
                                         input logic wr_lo, input logic wr_hi,
                                         input logic [31:0] wd);
    logic [31:0] lo;
    if (wr_lo) return {cnt[63:32], wd};
    if (wr_hi) begin
      lo = cnt[31:0] + 32'(inc);
      return {wd, lo};
    end
    return cnt + 64'(inc);
  endfunction

  function automatic void m_reset();
    m_cyc = '0; m_ins = '0; m_inh = '0; m_rdata = '0;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic re, input logic we, input logic [11:0] addr,
                      input logic [31:0] wd, input logic ret, input string tag);
    logic        owned, e_hit, e_ill, cy_inc, ir_inc;
    logic [31:0] rv;
    csr_re = re; csr_we = we; csr_addr = addr; csr_wdata = wd; instr_retire = ret;
    rv     = m_read(addr, owned);
    e_hit  = (re || we) && owned;
    e_ill  = we && (addr inside {12'hC00, 12'hC80, 12'hC02, 12'hC82});
    if (re) m_rdata = rv;
    cy_inc = !m_inh[0];
    ir_inc = ret && !m_inh[2];
    m_cyc = m_next(m_cyc, cy_inc, we && addr == 12'hB00, we && addr == 12'hB80, wd);
    m_ins = m_next(m_ins, ir_inc, we && addr == 12'hB02, we && addr == 12'hB82, wd);
    if (we && addr == 12'h320) m_inh = wd & 32'h5;
    @(posedge clk);
    #1;
    check({tag, ".rvalid"},  32'(csr_rvalid),  32'(re));
    check({tag, ".hit"},     32'(csr_hit),     32'(e_hit));
    check({tag, ".illegal"}, 32'(csr_illegal), 32'(e_ill));
    check({tag, ".rdata"},   csr_rdata,        m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, "idle");
  endtask

  task automatic rd(input logic [11:0] a, input string tag);
    step(1'b1, 1'b0, a, 32'h0, 1'b0, tag);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ret, input string tag);
    step(1'b0, 1'b1, a, d, ret, tag);
  endtask

  logic [11:0] addr_pool [12] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0,
                                   12'h321, 12'hB01};

  initial begin
    m_reset();
    #2;
    check("reset.rvalid",  32'(csr_rvalid),  32'h0);
    check("reset.hit",     32'(csr_hit),     32'h0);
    check("reset.illegal", 32'(csr_illegal), 32'h0);
    check("reset.rdata",   csr_rdata,        32'h0);
    #10 rst_n = 1'b1;

    // Free-running mcycle after reset release.
    idle(10);
    rd(12'hB00, "cyc10");
    check("cyc10.const", csr_rdata, 32'd10);
    idle(1);
    check("rvalid_pulse", 32'(csr_rvalid), 32'h0);

    // Low wrap carries into the high half on the same edge.
    wr(12'hB00, 32'hFFFF_FFFE, 1'b0, "wr_lo");
    wr(12'hB80, 32'h5, 1'b0, "wr_hi");
    rd(12'hB80, "hi_pre");
    rd(12'hB80, "hi_post");
    check("carry.const", csr_rdata, 32'h6);
    rd(12'hB00, "lo_post");

    // mcountinhibit.IR blocks retires; clearing it resumes counting.
    wr(12'h320, 32'h4, 1'b0, "inh_ir");
    rd(12'h320, "inh_rd");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, "ret_inh");
    rd(12'hB02, "ir_held");
    wr(12'h320, 32'h0, 1'b0, "inh_clr");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, "ret");
    rd(12'hB02, "ir_plus3");
    check("ir_plus3.const", csr_rdata, 32'd3);

    // Low write overrides retire and suppresses the carry; then a real carry.
    wr(12'hB02, 32'hFFFF_FFFF, 1'b0, "ir_lo_max");
    wr(12'hB02, 32'h0000_00AB, 1'b1, "ir_lo_wr_ret");
    rd(12'hB02, "ir_lo_rd");
    rd(12'hB82, "ir_hi_rd");
    wr(12'hB02, 32'hFFFF_FFFF, 1'b0, "ir_lo_max2");
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, "ir_wrap");
    rd(12'hB82, "ir_hi_carry");
    rd(12'hB02, "ir_lo_wrap");

    // Shadow writes are illegal and inert; unowned writes are ignored.
    wr(12'hC00, 32'h1234, 1'b0, "shadow_wr");
    rd(12'hC00, "shadow_rd");
    wr(12'h7C0, 32'hDEAD, 1'b0, "unowned_wr");
    rd(12'h7C0, "unowned_rd");

    // Same-cycle read and write returns the pre-write value.
    step(1'b1, 1'b1, 12'hB00, 32'h55, 1'b0, "rw_same");
    rd(12'hB00, "rw_after");

    // Random traffic with near-wrap data to exercise carries.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = addr_pool[$urandom_range(11)];
      d = ($urandom_range(1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step(1'($urandom_range(1)), ($urandom_range(3) == 0), a, d,
           1'($urandom_range(1)), "rand");
    end

    // Reset asserted while a read response is on the outputs.
    wr(12'h320, 32'h0, 1'b0, "pre_rst");
    rd(12'hB02, "inflight");
    #1 rst_n = 1'b0;
    csr_re = 1'b0; csr_we = 1'b0; instr_retire = 1'b0;
    m_reset();
    #1;
    check("midrst.rvalid",  32'(csr_rvalid),  32'h0);
    check("midrst.hit",     32'(csr_hit),     32'h0);
    check("midrst.illegal", 32'(csr_illegal), 32'h0);
    check("midrst.rdata",   csr_rdata,        32'h0);
    #3 rst_n = 1'b1;
    rd(12'hB00, "post_cy_lo");
    check("post_cy_lo.const", csr_rdata, 32'h0);
    rd(12'hB80, "post_cy_hi");
    rd(12'hB02, "post_ir_lo");
    rd(12'hB82, "post_ir_hi");
    rd(12'h320, "post_inh");
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
